// File: rtl/procesador_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | procesador_pkg : opcodes, NOP word and fetch state enum shared   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package procesador_pkg;

  localparam logic [3:0] OP_NOT = 4'b0110;
  localparam logic [3:0] OP_CMP = 4'b1000;
  localparam logic [3:0] OP_MOV = 4'b1011;
  localparam logic [3:0] OP_LD  = 4'b1100;
  localparam logic [3:0] OP_ST  = 4'b1101;
  localparam logic [3:0] OP_BT  = 4'b1110;
  localparam logic [3:0] OP_NOP = 4'b1111;

  localparam int          INSTR_WIDTH_DEF = 24;
  localparam logic [23:0] NOP_INSTR       = {OP_NOP, 20'h0_0000};

  typedef enum logic [0:0] {
    BUBBLE = 1'b0,
    FETCH  = 1'b1
  } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | if_id_reg : holdable / flushable IF/ID pipeline register         |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module if_id_reg
  import procesador_pkg::*;
#(
  parameter int PC_WIDTH    = 10,
  parameter int INSTR_WIDTH = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic                   flush,
  input  logic [INSTR_WIDTH-1:0] instr_in,
  input  logic [PC_WIDTH-1:0]    pc_in,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [PC_WIDTH-1:0]    pc,
  output logic                   valid,
  output logic [3:0]             opcode
);

  localparam logic [INSTR_WIDTH-1:0] NOP_WORD = {OP_NOP, {(INSTR_WIDTH-4){1'b0}}};

  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic                   valid_q, valid_d;

  // Flush beats load so a redirect always leaves a bubble behind.
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (flush) begin
      instr_d = NOP_WORD;
      pc_d    = '0;
      valid_d = 1'b0;
    end else if (load) begin
      instr_d = instr_in;
      pc_d    = pc_in;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q <= NOP_WORD;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign instr  = instr_q;
  assign pc     = pc_q;
  assign valid  = valid_q;
  assign opcode = instr_q[INSTR_WIDTH-1 -: 4];

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fetch_stage : PC, synchronous imem interface and IF/ID register  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module fetch_stage
  import procesador_pkg::*;
#(
  parameter int                PC_WIDTH    = 10,
  parameter int                INSTR_WIDTH = 24,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   redirect,
  input  logic [PC_WIDTH-1:0]    redirect_pc,
  output logic [PC_WIDTH-1:0]    imem_addr,
  output logic                   imem_re,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic [INSTR_WIDTH-1:0] if_id_instr,
  output logic [3:0]             if_id_opcode,
  output logic [PC_WIDTH-1:0]    if_id_pc,
  output logic                   if_id_valid
);

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] fetched_pc_q, fetched_pc_d;
  fetch_state_e        state_q, state_d;
  logic                ifid_load, ifid_flush;

  // BUBBLE means imem_rdata does not yet hold the word at fetched_pc.
  always_comb begin
    pc_d         = pc_q;
    fetched_pc_d = fetched_pc_q;
    state_d      = state_q;
    ifid_load    = 1'b0;
    ifid_flush   = 1'b0;
    if (redirect) begin
      pc_d       = redirect_pc;
      state_d    = BUBBLE;
      ifid_flush = 1'b1;
    end else if (!stall) begin
      fetched_pc_d = pc_q;
      pc_d         = pc_q + PC_WIDTH'(1);
      state_d      = FETCH;
      if (state_q == FETCH) begin
        ifid_load = 1'b1;
      end else begin
        ifid_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      fetched_pc_q <= RESET_PC;
      state_q      <= BUBBLE;
    end else begin
      pc_q         <= pc_d;
      fetched_pc_q <= fetched_pc_d;
      state_q      <= state_d;
    end
  end

  assign imem_addr = pc_q;
  assign imem_re   = ~stall | redirect;

  if_id_reg #(
    .PC_WIDTH    (PC_WIDTH),
    .INSTR_WIDTH (INSTR_WIDTH)
  ) u_if_id (
    .clk      (clk),
    .rst      (rst),
    .load     (ifid_load),
    .flush    (ifid_flush),
    .instr_in (imem_rdata),
    .pc_in    (fetched_pc_q),
    .instr    (if_id_instr),
    .pc       (if_id_pc),
    .valid    (if_id_valid),
    .opcode   (if_id_opcode)
  );

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_fetch_stage : directed self-checking bench for fetch_stage    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [9:0]  redirect_pc = '0;
  logic [9:0]  imem_addr;
  logic        imem_re;
  logic [23:0] imem_rdata = '0;
  logic [23:0] if_id_instr;
  logic [3:0]  if_id_opcode;
  logic [9:0]  if_id_pc;
  logic        if_id_valid;

  logic [23:0] mem [0:1023];
  int          n_tests = 0;
  int          n_fail  = 0;

  fetch_stage #(.PC_WIDTH(10), .INSTR_WIDTH(24), .RESET_PC(10'd0)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .imem_addr    (imem_addr),
    .imem_re      (imem_re),
    .imem_rdata   (imem_rdata),
    .if_id_instr  (if_id_instr),
    .if_id_opcode (if_id_opcode),
    .if_id_pc     (if_id_pc),
    .if_id_valid  (if_id_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (imem_re) imem_rdata <= mem[imem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, "_valid"}, 32'(if_id_valid), 32'd0);
    chk({tag, "_op"}, 32'(if_id_opcode), 32'hF);
  endtask

  task automatic chk_instr(input string tag, input logic [9:0] pc, input logic [23:0] word);
    chk({tag, "_valid"}, 32'(if_id_valid), 32'd1);
    chk({tag, "_pc"}, 32'(if_id_pc), 32'(pc));
    chk({tag, "_instr"}, 32'(if_id_instr), 32'(word));
    chk({tag, "_op"}, 32'(if_id_opcode), 32'(word[23:20]));
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 24'h300000 | 24'(i);
    mem[0] = 24'hB00001;
    mem[1] = 24'h800102;
    mem[2] = 24'hC00203;
    mem[3] = 24'hD00304;

    // Reset state
    tick(); tick();
    chk("rst_valid", 32'(if_id_valid), 32'd0);
    chk("rst_instr", 32'(if_id_instr), 32'hF00000);
    chk("rst_op", 32'(if_id_opcode), 32'hF);
    chk("rst_pc", 32'(if_id_pc), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    rst = 1'b0;

    // Free run: first valid on the second edge after release
    tick();
    chk_bubble("e1");
    chk("e1_addr", 32'(imem_addr), 32'd1);
    tick(); chk_instr("e2", 10'd0, 24'hB00001);
    tick(); chk_instr("e3", 10'd1, 24'h800102);
    tick(); chk_instr("e4", 10'd2, 24'hC00203);

    // Stall three cycles holding pc=2
    stall = 1'b1;
    #1;
    chk("stall_re", 32'(imem_re), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_instr("stall_hold", 10'd2, 24'hC00203);
      chk("stall_addr", 32'(imem_addr), 32'd4);
      chk("stall_re_h", 32'(imem_re), 32'd0);
    end
    stall = 1'b0;
    tick(); chk_instr("resume", 10'd3, 24'hD00304);
    tick(); chk_instr("e6", 10'd4, 24'h300004);
    tick(); chk_instr("e7", 10'd5, 24'h300005);

    // Redirect to 0x040
    redirect = 1'b1; redirect_pc = 10'h040;
    tick(); chk_bubble("rd1_b1");
    chk("rd1_addr", 32'(imem_addr), 32'h040);
    redirect = 1'b0;
    tick(); chk_bubble("rd1_b2");
    tick(); chk_instr("rd1_tgt", 10'h040, 24'h300040);
    tick(); chk_instr("rd1_nxt", 10'h041, 24'h300041);

    // Redirect and stall together: redirect wins
    redirect = 1'b1; stall = 1'b1; redirect_pc = 10'h100;
    #1;
    chk("rs_re", 32'(imem_re), 32'd1);
    tick(); chk_bubble("rs_b1");
    redirect = 1'b0; stall = 1'b0;
    tick(); chk_bubble("rs_b2");
    tick(); chk_instr("rs_tgt", 10'h100, 24'h300100);

    // Second redirect while in BUBBLE
    redirect = 1'b1; redirect_pc = 10'h080;
    tick(); chk_bubble("rr_b1");
    redirect_pc = 10'h0C0;
    tick(); chk_bubble("rr_b2");
    redirect = 1'b0;
    tick(); chk_bubble("rr_b3");
    tick(); chk_instr("rr_tgt", 10'h0C0, 24'h3000C0);
    tick(); chk_instr("rr_nxt", 10'h0C1, 24'h3000C1);

    // PC wrap past 0x3FF
    redirect = 1'b1; redirect_pc = 10'h3FE;
    tick(); redirect = 1'b0;
    tick();
    tick(); chk_instr("wr_3fe", 10'h3FE, 24'h3003FE);
    tick(); chk_instr("wr_3ff", 10'h3FF, 24'h3003FF);
    tick(); chk_instr("wr_000", 10'h000, 24'hB00001);

    // Asynchronous reset mid-cycle
    #2 rst = 1'b1;
    #1;
    chk("ar_valid", 32'(if_id_valid), 32'd0);
    chk("ar_instr", 32'(if_id_instr), 32'hF00000);
    chk("ar_pc", 32'(if_id_pc), 32'd0);
    chk("ar_addr", 32'(imem_addr), 32'd0);
    tick();
    rst = 1'b0;
    tick(); chk_bubble("ar_b1");
    tick(); chk_instr("ar_first", 10'd0, 24'hB00001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
